downscale_result_reader: RTL

// - Readback side of the downscaler: host-facing drain for the DST_W x DST_H output image buffer.
// - After the downscale core asserts done, streams every output pixel in raster order over valid/ready.
// - It is the read counterpart of the cfg_we/cfg_addr/cfg_data image loader.
// - Sits between the output BRAM (1-cycle read latency) and the JTAG/host capture logic.

---
 rtl/downscale_result_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/downscale_result_reader.sv
// Streams the DST_W x DST_H output buffer in raster order over valid/ready.
// Optional READER_CHECKSUM_EN adds chk_sum, a 16-bit sum of transferred pixels.
module downscale_result_reader #(
   parameter int DST_W  = 16,
   parameter int DST_H  = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_req,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_last,
   output logic              out_eol,
   output logic              busy,
   output logic              done
`ifdef READER_CHECKSUM_EN
   ,
   output logic [15:0]       chk_sum
`endif
);

   localparam int NPIX  = DST_W * DST_H;
   localparam int COL_W = (DST_W > 1) ? $clog2(DST_W) : 1;
   localparam logic [ADDR_W:0]  NPIX_W   = (ADDR_W+1)'(NPIX);
   localparam logic [ADDR_W:0]  LAST_IDX = (ADDR_W+1)'(NPIX - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(DST_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   rd_ptr_q;
   logic [COL_W-1:0]  col_q;
   logic              inflight_q;
   logic              inf_last_q;
   logic              inf_eol_q;
   logic [9:0]        fifo_q [2];
   logic              wp_q;
   logic              rp_q;
   logic [1:0]        count_q;
   logic              issue;
   logic              pop;
   logic [2:0]        occ;
   logic [9:0]        head;

   // Occupancy counts the read in flight so the FIFO can never overflow.
   assign occ       = {1'b0, count_q} + {2'b00, inflight_q};
   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid & out_ready;
   assign head      = fifo_q[rp_q];
   assign out_data  = out_valid ? head[9:2] : 8'd0;
   assign out_last  = out_valid & head[1];
   assign out_eol   = out_valid & head[0];

   assign mem_rd_en   = issue;
   assign mem_rd_addr = rd_ptr_q[ADDR_W-1:0];
   assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done        = (state_q == S_FIN);

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_req) state_d = S_RUN;
         end
         S_RUN: begin
            if ((rd_ptr_q < NPIX_W) &&
                ((occ < 3'd2) || (pop && occ == 3'd2)))
               issue = 1'b1;
            if (issue && rd_ptr_q == LAST_IDX) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if ((occ == 3'd0) || (occ == 3'd1 && pop)) state_d = S_FIN;
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= '0;
         col_q      <= '0;
         inflight_q <= 1'b0;
         inf_last_q <= 1'b0;
         inf_eol_q  <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wp_q       <= 1'b0;
         rp_q       <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if (state_q == S_IDLE && start_req) begin
            rd_ptr_q <= '0;
            col_q    <= '0;
         end else if (issue) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            col_q      <= (col_q == LAST_COL) ? '0 : col_q + 1'b1;
            inf_last_q <= (rd_ptr_q == LAST_IDX);
            inf_eol_q  <= (col_q == LAST_COL);
         end
         // Flags travel with the pixel so the head is self-describing.
         if (inflight_q) begin
            fifo_q[wp_q] <= {mem_rd_data, inf_last_q, inf_eol_q};
            wp_q         <= ~wp_q;
         end
         if (pop) rp_q <= ~rp_q;
         unique case ({inflight_q, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef READER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         chk_sum <= 16'd0;
      else if (state_q == S_IDLE && start_req)
         chk_sum <= 16'd0;
      else if (pop)
         chk_sum <= chk_sum + {8'd0, out_data};
   end
`endif

endmodule
